// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - Wishbone-side sequencer that drives single-byte SPI transfers through simple_spi_top.
// Optional access timeout is compiled in with `define SPI_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer #(
  parameter logic [7:0]  SPCR_INIT   = 8'h50,
  parameter logic [7:0]  SPER_INIT   = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic       req1_valid_i,
  input  logic [7:0] req0_dat_i,
  input  logic [7:0] req1_dat_i,
  output logic       req0_ready_o,
  output logic       req1_ready_o,
  output logic       rsp0_valid_o,
  output logic       rsp1_valid_o,
  output logic [7:0] rsp_dat_o,
  output logic [1:0] ss_n_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;
  localparam logic [1:0] ADR_SPER = 2'd3;

  typedef enum logic [2:0] {
    S_INIT_CR, S_INIT_ER, S_IDLE, S_WR_DR, S_RD_SR, S_RD_DR, S_DONE
  } state_e;

  state_e     state_q, state_d, acc_next;
  logic       cyc_q, cyc_d;
  logic [1:0] ss_q, ss_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       grant0, grant1;
  logic       acc_st, xfer_st, acc_we;
  logic [1:0] acc_adr;
  logic [7:0] acc_dat;
  logic       abort;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    ss_d     = ss_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    grant0   = 1'b0;
    grant1   = 1'b0;
    acc_st   = 1'b0;
    xfer_st  = 1'b0;
    acc_we   = 1'b0;
    acc_adr  = ADR_SPCR;
    acc_dat  = 8'h00;
    acc_next = state_q;
    case (state_q)
      S_INIT_CR: begin
        acc_st = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPCR; acc_dat = SPCR_INIT;
        acc_next = S_INIT_ER;
      end
      S_INIT_ER: begin
        acc_st = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPER; acc_dat = SPER_INIT;
        acc_next = S_IDLE;
      end
      S_IDLE: begin
        // last_q names the requester served most recently; the other one wins a tie
        if (req0_valid_i && (!req1_valid_i || last_q)) grant0 = 1'b1;
        else if (req1_valid_i)                          grant1 = 1'b1;
        if (grant0 || grant1) begin
          gnt_d   = grant1;
          last_d  = grant1;
          tx_d    = grant1 ? req1_dat_i : req0_dat_i;
          ss_d    = grant1 ? 2'b01 : 2'b10;
          state_d = S_WR_DR;
        end
      end
      S_WR_DR: begin
        acc_st = 1'b1; xfer_st = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPDR; acc_dat = tx_q;
        acc_next = S_RD_SR;
      end
      S_RD_SR: begin
        acc_st = 1'b1; xfer_st = 1'b1; acc_adr = ADR_SPSR;
        acc_next = dat_i[0] ? S_RD_SR : S_RD_DR;
      end
      S_RD_DR: begin
        acc_st = 1'b1; xfer_st = 1'b1; acc_adr = ADR_SPDR;
        acc_next = S_DONE;
      end
      S_DONE: begin
        ss_d    = 2'b11;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT_CR;
    endcase

    // cyc_q low on state entry gives the mandatory idle cycle between accesses
    if (acc_st) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
      end else if (ack_i) begin
        cyc_d   = 1'b0;
        state_d = acc_next;
        if (state_q == S_RD_DR) rx_d = dat_i;
      end
    end

    if (abort) begin
      cyc_d   = 1'b0;
      ss_d    = 2'b11;
      rx_d    = 8'hFF;
      state_d = xfer_st ? S_IDLE : S_INIT_CR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_INIT_CR;
      cyc_q   <= 1'b0;
      ss_q    <= 2'b11;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ss_q    <= ss_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Restarts only on a state change, so repeated SPSR polls share one budget
  always_comb begin
    tmo_d = tmo_q;
    if (abort || (state_d != state_q)) tmo_d = '0;
    else if (cyc_q)                    tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign abort = cyc_q & ~ack_i & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
  assign abort      = 1'b0;
`endif

  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = cyc_q & acc_we;
  assign adr_o        = cyc_q ? acc_adr : 2'd0;
  assign dat_o        = cyc_q ? acc_dat : 8'h00;
  assign ss_n_o       = ss_q;
  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign rsp0_valid_o = ((state_q == S_DONE) || (abort && xfer_st)) && !gnt_q;
  assign rsp1_valid_o = ((state_q == S_DONE) || (abort && xfer_st)) &&  gnt_q;
  assign rsp_dat_o    = abort ? 8'hFF : rx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign err_o        = abort;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - randomized, model-checked bench for spi_xfer_sequencer (default build).
module tb_spi_xfer_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [7:0] req0_dat_i = 8'h00, req1_dat_i = 8'h00;
  logic       req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o;
  logic [7:0] rsp_dat_o;
  logic [1:0] ss_n_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = 8'h00;
  logic       ack_i = 1'b0;
  logic       busy_o, err_o;

  spi_xfer_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_dat_i(req0_dat_i), .req1_dat_i(req1_dat_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp_dat_o(rsp_dat_o), .ss_n_o(ss_n_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Stimulus-owned scenario knobs
  bit         fixed_lat = 1'b1;
  int         cfg_empty = 0;
  logic [7:0] cfg_spdr = 8'h00;

  // Monitor-owned results
  logic [10:0] acc_log[$];
  int          mon_sr_reads = 0;

  // Slave-owned state
  int lat_left = 0;
  int empty_left = 0;
  bit in_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // simple_spi register-file stand-in: SPSR reports RFEMPTY cfg_empty times per transfer
  always @(posedge clk_i) begin
    #1;
    if (!rst_i || !(cyc_o && stb_o)) begin
      ack_i  = 1'b0;
      in_acc = 1'b0;
      dat_i  = 8'($urandom);
    end else begin
      if (!in_acc) begin
        in_acc   = 1'b1;
        lat_left = fixed_lat ? 1 : int'($urandom_range(0, 3));
      end
      if (lat_left == 0) begin
        ack_i = 1'b1;
        if (we_o) begin
          if (adr_o == 2'd2) empty_left = cfg_empty;
          dat_i = 8'($urandom);
        end else if (adr_o == 2'd1) begin
          if (empty_left > 0) begin dat_i = 8'h05; empty_left--; end
          else dat_i = 8'h04;
        end else if (adr_o == 2'd2) begin
          dat_i = cfg_spdr;
        end else begin
          dat_i = 8'($urandom);
        end
      end else begin
        ack_i = 1'b0;
        lat_left--;
        dat_i = 8'($urandom);
      end
    end
  end

  task automatic monitor();
    logic pcyc, pack, prst, pwe;
    logic [1:0] padr;
    logic [7:0] pdat, etx, erx;
    bit inflight, set_if, clr_if, seq_ok;
    int mg, mlast, eg, k, nsr;
    logic [10:0] exp_q[$];
    pcyc = 0; pack = 0; prst = 0; pwe = 0; padr = 0; pdat = 0;
    inflight = 0; mg = 0; mlast = 1; eg = 0; k = 0; etx = 0; erx = 0;
    forever begin
      @(negedge clk_i);
      set_if = 0; clr_if = 0;
      if (!rst_i) begin
        inflight = 0; mlast = 1; acc_log.delete();
        check("rst_cyc", cyc_o, 1'b0);
        check("rst_ss", ss_n_o, 2'b11);
      end else begin
        check("ss_n", ss_n_o, inflight ? ((mg == 1) ? 2'b01 : 2'b10) : 2'b11);
        check("stb", stb_o, cyc_o);
        check("err", err_o, 1'b0);
        if (prst && pcyc && pack) check("gap", cyc_o, 1'b0);
        if (prst && pcyc && !pack && cyc_o) check("hold", {we_o, adr_o, dat_o}, {pwe, padr, pdat});
        if (cyc_o && ack_i) acc_log.push_back({we_o, adr_o, we_o ? dat_o : dat_i});
        if (req0_ready_o || req1_ready_o) begin
          if (req0_valid_i && req1_valid_i) eg = (mlast == 1) ? 0 : 1;
          else eg = req1_valid_i ? 1 : 0;
          check("grant", {req1_ready_o, req0_ready_o}, (eg == 1) ? 2'b10 : 2'b01);
          check("grant_in_flight", inflight, 1'b0);
          mg = eg; mlast = eg;
          etx = (eg == 1) ? req1_dat_i : req0_dat_i;
          k = cfg_empty; erx = cfg_spdr;
          acc_log.delete();
          set_if = 1;
        end
        if (rsp0_valid_o || rsp1_valid_o) begin
          check("rsp_expected", inflight, 1'b1);
          check("rsp_id", {rsp1_valid_o, rsp0_valid_o}, (mg == 1) ? 2'b10 : 2'b01);
          check("rsp_dat", rsp_dat_o, erx);
          exp_q.delete();
          exp_q.push_back({1'b1, 2'd2, etx});
          for (int i = 0; i <= k; i++) exp_q.push_back({1'b0, 2'd1, (i < k) ? 8'h05 : 8'h04});
          exp_q.push_back({1'b0, 2'd2, erx});
          seq_ok = (exp_q.size() == acc_log.size());
          if (seq_ok) foreach (exp_q[i]) if (exp_q[i] !== acc_log[i]) seq_ok = 0;
          check("access_seq", seq_ok, 1'b1);
          nsr = 0;
          foreach (acc_log[i]) if (acc_log[i][10:8] == 3'b001) nsr++;
          mon_sr_reads = nsr;
          clr_if = 1;
        end
        if (set_if) inflight = 1;
        if (clr_if) inflight = 0;
      end
      pcyc = cyc_o; pack = ack_i; prst = rst_i; pwe = we_o; padr = adr_o; pdat = dat_o;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk_i); n++; end while (busy_o && n < 300);
    check(name, busy_o, 1'b0);
  endtask

  task automatic check_init_log(input string name);
    check({name, "_cnt"}, acc_log.size(), 2);
    check({name, "_cr"}, (acc_log.size() > 0) ? acc_log[0] : 11'h7FF, {1'b1, 2'd0, 8'h50});
    check({name, "_er"}, (acc_log.size() > 1) ? acc_log[1] : 11'h7FF, {1'b1, 2'd3, 8'h00});
  endtask

  task automatic do_xfer(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                         input int k, input logic [7:0] spdr,
                         output int gid, output int rid, output logic [7:0] rdat, output logic [1:0] ss_mid);
    bit got;
    gid = -1; rid = -1; rdat = 8'h00; ss_mid = 2'b00;
    @(posedge clk_i); #1;
    cfg_empty = k; cfg_spdr = spdr;
    req0_valid_i = v0; req1_valid_i = v1; req0_dat_i = d0; req1_dat_i = d1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      if (req0_ready_o || req1_ready_o) begin got = 1; gid = req1_ready_o ? 1 : 0; end
    end
    check("grant_timeout", got, 1'b1);
    if (got) begin
      @(posedge clk_i); #1;
      if (gid == 0) req0_valid_i = 1'b0;
      else req1_valid_i = 1'b0;
      @(negedge clk_i);
      ss_mid = ss_n_o;
      got = 0;
      for (int i = 0; i < 500 && !got; i++) begin
        @(negedge clk_i);
        if (rsp0_valid_o || rsp1_valid_o) begin
          got = 1; rid = rsp1_valid_o ? 1 : 0; rdat = rsp_dat_o;
        end
      end
      check("rsp_timeout", got, 1'b1);
    end
  endtask

  initial begin
    int gid, rid, n;
    logic [7:0] rdat;
    logic [1:0] ss_mid;
    bit v0, v1;
    fork monitor(); join_none

    #2 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b1);
    check("rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 13'h0);
    check("rst_ss_n", ss_n_o, 2'b11);
    check("rst_ready", {req1_ready_o, req0_ready_o}, 2'b00);
    check("rst_rsp", {rsp1_valid_o, rsp0_valid_o, rsp_dat_o}, 10'h0);
    check("rst_err", err_o, 1'b0);

    // Init sequence, then a single req0 byte with two busy SPSR polls
    @(posedge clk_i); #1 rst_i = 1'b1;
    wait_idle("init_idle");
    check_init_log("init");

    do_xfer(1'b1, 1'b0, 8'hA5, 8'h00, 2, 8'h3C, gid, rid, rdat, ss_mid);
    check("x1_gid", gid, 0);
    check("x1_rid", rid, 0);
    check("x1_rdat", rdat, 8'h3C);
    check("x1_ss", ss_mid, 2'b10);
    check("x1_sr_reads", mon_sr_reads, 3);

    // Reset while SPSR polling is in progress
    @(posedge clk_i); #1;
    cfg_empty = 1000; cfg_spdr = 8'h11;
    req1_dat_i = 8'h77; req1_valid_i = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!req1_ready_o && n < 100);
    @(posedge clk_i); #1 req1_valid_i = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!(cyc_o && !we_o && adr_o == 2'd1) && n < 100);
    check("sr_reached", {cyc_o, we_o, adr_o}, 4'b1001);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_cyc", {cyc_o, stb_o}, 2'b00);
    check("midrst_ss", ss_n_o, 2'b11);
    check("midrst_busy", busy_o, 1'b1);
    cfg_empty = 0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1 rst_i = 1'b1;
    wait_idle("reinit_idle");
    check_init_log("reinit");

    // Both requesters contending from a fresh round-robin pointer
    do_xfer(1'b1, 1'b1, 8'h01, 8'h02, 0, 8'hC1, gid, rid, rdat, ss_mid);
    check("rr0", gid, 0);
    do_xfer(1'b1, 1'b1, 8'h03, 8'h04, 1, 8'hC2, gid, rid, rdat, ss_mid);
    check("rr1", gid, 1);
    check("rr1_ss", ss_mid, 2'b01);
    do_xfer(1'b1, 1'b1, 8'h05, 8'h06, 0, 8'hC3, gid, rid, rdat, ss_mid);
    check("rr2", gid, 0);
    check("rr2_rdat", rdat, 8'hC3);

    // Random traffic with random ack latency
    fixed_lat = 1'b0;
    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(1, 3));
      v0 = n[0]; v1 = n[1];
      do_xfer(v0, v1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 8'($urandom),
              gid, rid, rdat, ss_mid);
      check("rnd_rid", rid, gid);
    end
    @(posedge clk_i); #1 req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    wait_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
